des_key_sched: RTL

//  Sequential DES key schedule. Produces the 16 48-bit round subkeys from one
//  64-bit key, one per accepted handshake. Encrypt mode rotates C/D left
//  (K1..K16); decrypt mode rotates right (K16..K1 order). Sits between key

---
 rtl/des_key_sched.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/des_key_sched.sv
// DES key schedule: PC-1 load, per-round C/D rotate, PC-2 subkey output.
// Ports: i_Clk/i_Rst_n, i_Key, i_fDecrypt, i_Start, i_fReady -> o_SubKey, o_fValid, o_Round, o_Busy, o_fDone.
module des_key_sched (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic [63:0] i_Key,
  input  logic        i_fDecrypt,
  input  logic        i_Start,
  input  logic        i_fReady,
  output logic [47:0] o_SubKey,
  output logic        o_fValid,
  output logic [3:0]  o_Round,
  output logic        o_Busy,
  output logic        o_fDone
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    GEN  = 2'd2
  } state_t;

  // Table entries use DES numbering: bit 1 is the MSB.
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  function automatic logic [55:0] pc1(
    input logic [63:0] k
  );
    logic [55:0] o;
    logic [5:0]  ix;
    o = '0;
    for (int i = 0; i < 56; i++) begin
      ix = 6'(64 - PC1[i]);
      o[55-i] = k[ix];
    end
    return o;
  endfunction

  function automatic logic [47:0] pc2(
    input logic [55:0] cd
  );
    logic [47:0] o;
    logic [5:0]  ix;
    o = '0;
    for (int i = 0; i < 48; i++) begin
      ix = 6'(56 - PC2[i]);
      o[47-i] = cd[ix];
    end
    return o;
  endfunction

  // Decrypt issue 0 is the unrotated PC-1 output (== C16/D16).
  function automatic logic [1:0] shamt(
    input logic       dec,
    input logic [3:0] r
  );
    if (r == 4'd0)
      return dec ? 2'd0 : 2'd1;
    if (r == 4'd1 || r == 4'd8 || r == 4'd15)
      return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [27:0] rot(
    input logic [27:0] x,
    input logic        dec,
    input logic [1:0]  n
  );
    logic [27:0] o;
    o = x;
    unique case (1'b1)
      (n == 2'd1 && !dec): o = {x[26:0], x[27]};
      (n == 2'd2 && !dec): o = {x[25:0], x[27:26]};
      (n == 2'd1 &&  dec): o = {x[0], x[27:1]};
      (n == 2'd2 &&  dec): o = {x[1:0], x[27:2]};
      default:             o = x;
    endcase
    return o;
  endfunction

  state_t      state_q, state_d;
  logic [55:0] cd_q, cd_d;
  logic        mode_q, mode_d;
  logic [3:0]  round_q, round_d;
  logic [47:0] key_q, key_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic        busy_q;

  logic [3:0]  nidx;
  logic [1:0]  n;
  logic [55:0] cd_rot;

  // Rotation for the subkey about to be issued.
  always_comb begin
    nidx   = (state_q == LOAD) ? 4'd0 : round_q + 4'd1;
    n      = shamt(mode_q, nidx);
    cd_rot = {rot(cd_q[55:28], mode_q, n),
              rot(cd_q[27:0],  mode_q, n)};
  end

  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    mode_d  = mode_q;
    round_d = round_q;
    key_d   = key_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_Start) begin
          cd_d    = pc1(i_Key);
          mode_d  = i_fDecrypt;
          round_d = 4'd0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cd_d    = cd_rot;
        key_d   = pc2(cd_rot);
        valid_d = 1'b1;
        state_d = GEN;
      end
      GEN: begin
        if (valid_q && i_fReady) begin
          if (round_q != 4'd15) begin
            round_d = nidx;
            cd_d    = cd_rot;
            key_d   = pc2(cd_rot);
          end else begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            round_d = 4'd0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= IDLE;
      cd_q    <= '0;
      mode_q  <= 1'b0;
      round_q <= '0;
      key_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      mode_q  <= mode_d;
      round_q <= round_d;
      key_q   <= key_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign o_SubKey = key_q;
  assign o_fValid = valid_q;
  assign o_Round  = round_q;
  assign o_Busy   = busy_q;
  assign o_fDone  = done_q;

endmodule
